// File: rtl/wbrgbpwm_pkg.sv
// Shared register map, field positions and channel indexing for wbrgbpwm.
package wbrgbpwm_pkg;

  // Word offsets on the Wishbone bus
  localparam int unsigned REG_CTRL     = 0;
  localparam int unsigned REG_STATUS   = 1;
  localparam int unsigned REG_LED_BASE = 2;

  // CTRL fields
  localparam int unsigned CTRL_EN_BIT  = 0;
  localparam int unsigned CTRL_DIV_LSB = 8;
  localparam int unsigned CTRL_DIV_MSB = 15;

  // LED register fields; each colour field is 10 bits wide regardless of PWMBITS
  localparam int unsigned LED_FIELD_W = 10;
  localparam int unsigned LED_B_LSB   = 0;
  localparam int unsigned LED_G_LSB   = 10;
  localparam int unsigned LED_R_LSB   = 20;
  localparam int unsigned LED_IMM_BIT = 31;

  // Channel index within an LED; also its bit offset inside the LED's o_led triple
  typedef enum logic [1:0] {
    CH_B = 2'd0,
    CH_G = 2'd1,
    CH_R = 2'd2
  } ch_e;

  // Bit position of a channel's field in the LED register
  function automatic int unsigned ch_lsb(ch_e ch);
    case (ch)
      CH_R:    return LED_R_LSB;
      CH_G:    return LED_G_LSB;
      default: return LED_B_LSB;
    endcase
  endfunction

endpackage

// File: rtl/wbrgbpwm_channel.sv
// One colour channel: target/current level, one-step-per-tick ramp, registered PWM compare.
module rgbpwm_channel #(
  parameter int PWMBITS = 9
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               wr_i,
  input  logic               imm_i,
  input  logic [PWMBITS-1:0] level_i,
  input  logic               tick_i,
  input  logic               en_i,
  input  logic [PWMBITS-1:0] cnt_i,
  output logic [PWMBITS-1:0] cur_o,
  output logic               ramping_o,
  output logic               ramping_d_o,
  output logic               pwm_o
);

  logic [PWMBITS-1:0] tgt_q, tgt_d;
  logic [PWMBITS-1:0] cur_q, cur_d;
  logic               pwm_q;

  // Next level: an immediate write overrides any tick; otherwise step once toward the (new) target
  always_comb begin
    tgt_d = wr_i ? level_i : tgt_q;
    cur_d = cur_q;
    if (wr_i && imm_i) begin
      cur_d = level_i;
    end else if (tick_i && (cur_q != tgt_d)) begin
      if (cur_q < tgt_d) cur_d = cur_q + PWMBITS'(1);
      else               cur_d = cur_q - PWMBITS'(1);
    end
  end

  // Level state and the registered PWM comparator
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      tgt_q <= '0;
      cur_q <= '0;
      pwm_q <= 1'b0;
    end else begin
      tgt_q <= tgt_d;
      cur_q <= cur_d;
      pwm_q <= en_i && (cnt_i < cur_q);
    end
  end

  assign cur_o       = cur_q;
  assign ramping_o   = (cur_q != tgt_q);
  assign ramping_d_o = (cur_d != tgt_d);
  assign pwm_o       = pwm_q;

endmodule

// File: rtl/wbrgbpwm.sv
// Wishbone slave driving NLEDS RGB LEDs with ramped PWM levels and a ramp-done interrupt.
module wbrgbpwm
  import wbrgbpwm_pkg::*;
#(
  parameter int         NLEDS       = 4,
  parameter int         PWMBITS     = 9,
  parameter int         AW          = 5,
  parameter logic [7:0] RAMPDIV_RST = 8'd0
) (
  input  logic               i_clk,
  input  logic               i_reset_n,
  input  logic               i_wb_cyc,
  input  logic               i_wb_stb,
  input  logic               i_wb_we,
  input  logic [AW-1:0]      i_wb_addr,
  input  logic [31:0]        i_wb_data,
  output logic               o_wb_ack,
  output logic               o_wb_stall,
  output logic [31:0]        o_wb_data,
  output logic [3*NLEDS-1:0] o_led,
  output logic               o_int
);

  localparam int NCH = 3 * NLEDS;

  logic               bus_req, bus_wr, ctrl_wr, tick;
  logic [31:0]        addr_ext;
  logic               en_q;
  logic [7:0]         div_q, presc_q, presc_d;
  logic [PWMBITS-1:0] cnt_q;
  logic               ack_q, int_q;
  logic [31:0]        rdata_q, rdata_d;
  logic [NLEDS-1:0]   led_wr, led_ramp, led_ramp_d;
  logic [NCH-1:0]     ch_ramp, ch_ramp_d, ch_pwm;
  logic [PWMBITS-1:0] ch_cur [NCH];
  logic [31:0]        led_word [NLEDS];
  logic               unused_bits;

  assign bus_req  = i_wb_cyc && i_wb_stb;
  assign bus_wr   = bus_req && i_wb_we;
  assign addr_ext = 32'(i_wb_addr);
  assign ctrl_wr  = bus_wr && (addr_ext == 32'(REG_CTRL));

  // Prescaler wraps after RAMPDIV+1 clocks; a CTRL write restarts it from zero
  assign tick    = (presc_q == div_q);
  assign presc_d = (ctrl_wr || tick) ? 8'd0 : presc_q + 8'd1;

  // Control register, ramp prescaler and the shared free-running PWM counter
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      en_q    <= 1'b0;
      div_q   <= RAMPDIV_RST;
      presc_q <= 8'd0;
      cnt_q   <= '0;
    end else begin
      if (ctrl_wr) begin
        en_q  <= i_wb_data[CTRL_EN_BIT];
        div_q <= i_wb_data[CTRL_DIV_MSB:CTRL_DIV_LSB];
      end
      presc_q <= presc_d;
      cnt_q   <= cnt_q + PWMBITS'(1);
    end
  end

  genvar gi, gc;
  generate
    for (gi = 0; gi < NLEDS; gi++) begin : g_led
      logic [31:0] word;

      assign led_wr[gi]     = bus_wr && (addr_ext == 32'(REG_LED_BASE + gi));
      assign led_ramp[gi]   = |ch_ramp[3*gi +: 3];
      assign led_ramp_d[gi] = |ch_ramp_d[3*gi +: 3];

      for (gc = 0; gc < 3; gc++) begin : g_ch
        localparam int unsigned LSB = ch_lsb(ch_e'(gc));
        rgbpwm_channel #(
          .PWMBITS(PWMBITS)
        ) u_ch (
          .clk_i      (i_clk),
          .rst_ni     (i_reset_n),
          .wr_i       (led_wr[gi]),
          .imm_i      (i_wb_data[LED_IMM_BIT]),
          .level_i    (i_wb_data[LSB +: PWMBITS]),
          .tick_i     (tick),
          .en_i       (en_q),
          .cnt_i      (cnt_q),
          .cur_o      (ch_cur[3*gi+gc]),
          .ramping_o  (ch_ramp[3*gi+gc]),
          .ramping_d_o(ch_ramp_d[3*gi+gc]),
          .pwm_o      (ch_pwm[3*gi+gc])
        );
      end

      // Readback word: current levels in the write layout, top bit flags an active ramp
      always_comb begin
        word = '0;
        word[LED_IMM_BIT]              = led_ramp[gi];
        word[LED_R_LSB +: PWMBITS]     = ch_cur[3*gi+int'(CH_R)];
        word[LED_G_LSB +: PWMBITS]     = ch_cur[3*gi+int'(CH_G)];
        word[LED_B_LSB +: PWMBITS]     = ch_cur[3*gi+int'(CH_B)];
      end

      assign led_word[gi] = word;
    end
  endgenerate

  // Read mux decoded from the address presented in the strobe cycle
  always_comb begin
    rdata_d = '0;
    if (addr_ext == 32'(REG_CTRL)) begin
      rdata_d[CTRL_EN_BIT]               = en_q;
      rdata_d[CTRL_DIV_MSB:CTRL_DIV_LSB] = div_q;
    end else if (addr_ext == 32'(REG_STATUS)) begin
      rdata_d[NLEDS-1:0] = led_ramp;
    end else begin
      for (int k = 0; k < NLEDS; k++) begin
        if (addr_ext == 32'(REG_LED_BASE) + 32'(k)) rdata_d = led_word[k];
      end
    end
  end

  // Single-cycle ack, registered read data, and ramp-done pulse on any LED ramp bit falling
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      ack_q   <= 1'b0;
      rdata_q <= '0;
      int_q   <= 1'b0;
    end else begin
      ack_q   <= bus_req;
      rdata_q <= rdata_d;
      int_q   <= |(led_ramp & ~led_ramp_d);
    end
  end

  assign o_wb_ack    = ack_q;
  assign o_wb_stall  = 1'b0;
  assign o_wb_data   = rdata_q;
  assign o_led       = ch_pwm;
  assign o_int       = int_q;
  assign unused_bits = ^i_wb_data;

endmodule

// File: tb/tb_wbrgbpwm.sv
// Self-checking bench for wbrgbpwm: register table, directed ramp/PWM corners, random traffic vs model.
`timescale 1ns/1ps
module tb_wbrgbpwm;

  localparam int         NLEDS    = 4;
  localparam int         PWMBITS  = 9;
  localparam int         AW       = 5;
  localparam logic [7:0] RDIV_RST = 8'h05;
  localparam int         NCH      = 3 * NLEDS;
  localparam int         LMASK    = (1 << PWMBITS) - 1;

  logic             i_clk = 1'b0;
  logic             i_reset_n = 1'b0;
  logic             cyc = 1'b0, stb = 1'b0, we = 1'b0;
  logic [AW-1:0]    addr = '0;
  logic [31:0]      wdata = '0;
  logic             o_wb_ack, o_wb_stall, o_int;
  logic [31:0]      o_wb_data;
  logic [NCH-1:0]   o_led;

  always #5 i_clk = ~i_clk;

  wbrgbpwm #(
    .NLEDS(NLEDS), .PWMBITS(PWMBITS), .AW(AW), .RAMPDIV_RST(RDIV_RST)
  ) dut (
    .i_clk(i_clk), .i_reset_n(i_reset_n),
    .i_wb_cyc(cyc), .i_wb_stb(stb), .i_wb_we(we),
    .i_wb_addr(addr), .i_wb_data(wdata),
    .o_wb_ack(o_wb_ack), .o_wb_stall(o_wb_stall), .o_wb_data(o_wb_data),
    .o_led(o_led), .o_int(o_int)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int int_pulses = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural reference model ----------------
  bit             m_en = 1'b0;
  int             m_div = int'(RDIV_RST);
  int             m_presc = 0, m_cnt = 0;
  int             m_cur [NCH];
  int             m_tgt [NCH];
  bit             e_ack = 1'b0, e_int = 1'b0;
  logic [31:0]    e_data = '0;
  logic [NCH-1:0] e_led = '0;

  initial begin
    for (int c = 0; c < NCH; c++) begin
      m_cur[c] = 0;
      m_tgt[c] = 0;
    end
  end

  function automatic bit m_ramp(int k);
    return (m_cur[3*k] != m_tgt[3*k]) || (m_cur[3*k+1] != m_tgt[3*k+1]) ||
           (m_cur[3*k+2] != m_tgt[3*k+2]);
  endfunction

  function automatic logic [31:0] model_read(int a);
    logic [31:0] r;
    logic [7:0]  dv;
    r = '0;
    if (a == 0) begin
      dv = 8'(m_div);
      r[15:8] = dv;
      r[0] = m_en;
    end else if (a == 1) begin
      for (int k = 0; k < NLEDS; k++) r[k] = m_ramp(k);
    end else if (a >= 2 && a < 2 + NLEDS) begin
      r[31]    = m_ramp(a - 2);
      r[29:20] = 10'(m_cur[3*(a-2)+2]);
      r[19:10] = 10'(m_cur[3*(a-2)+1]);
      r[9:0]   = 10'(m_cur[3*(a-2)]);
    end
    return r;
  endfunction

  // Model advances one clock using the bus inputs present during the cycle
  always @(posedge i_clk or negedge i_reset_n) begin
    int a;
    int lvl;
    bit tk;
    bit old_r [NLEDS];
    bit imm_ch [NCH];
    if (!i_reset_n) begin
      m_en = 1'b0; m_div = int'(RDIV_RST); m_presc = 0; m_cnt = 0;
      for (int c = 0; c < NCH; c++) begin m_cur[c] = 0; m_tgt[c] = 0; end
      e_ack = 1'b0; e_int = 1'b0; e_data = '0; e_led = '0;
    end else begin
      a = int'(addr);
      e_ack  = cyc && stb;
      e_data = model_read(a);
      for (int k = 0; k < NLEDS; k++) old_r[k] = m_ramp(k);
      for (int c = 0; c < NCH; c++) begin
        e_led[c]  = m_en && (m_cnt < m_cur[c]);
        imm_ch[c] = 1'b0;
      end
      tk      = (m_presc == m_div);
      m_presc = tk ? 0 : m_presc + 1;
      m_cnt   = (m_cnt + 1) & LMASK;
      if (cyc && stb && we) begin
        if (a == 0) begin
          m_en = wdata[0]; m_div = int'(wdata[15:8]); m_presc = 0;
        end else if (a >= 2 && a < 2 + NLEDS) begin
          for (int c = 0; c < 3; c++) begin
            lvl = int'(wdata >> (10 * c)) & LMASK;
            m_tgt[3*(a-2)+c] = lvl;
            if (wdata[31]) begin
              m_cur[3*(a-2)+c]  = lvl;
              imm_ch[3*(a-2)+c] = 1'b1;
            end
          end
        end
      end
      if (tk) begin
        for (int c = 0; c < NCH; c++) begin
          if (!imm_ch[c]) begin
            if (m_cur[c] < m_tgt[c]) m_cur[c] = m_cur[c] + 1;
            else if (m_cur[c] > m_tgt[c]) m_cur[c] = m_cur[c] - 1;
          end
        end
      end
      e_int = 1'b0;
      for (int k = 0; k < NLEDS; k++) if (old_r[k] && !m_ramp(k)) e_int = 1'b1;
    end
  end

  // Every cycle: outputs against the model, away from the active edge
  always @(negedge i_clk) begin
    check("cycle_ack_int_led", 64'({o_wb_ack, o_int, o_led}), 64'({e_ack, e_int, e_led}));
    if (e_ack) check("cycle_rdata", 64'(o_wb_data), 64'(e_data));
    if (o_int) int_pulses++;
  end

  // One bus transaction; call at a negedge, returns at the negedge where ack is visible
  task automatic xact(input bit w, input int a, input logic [31:0] d, output logic [31:0] rd);
    cyc = 1'b1; stb = 1'b1; we = w; addr = AW'(a); wdata = d;
    @(posedge i_clk);
    @(negedge i_clk);
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
    rd = o_wb_data;
    $display("[TB] %s addr=%0d wdata=0x%08h rdata=0x%08h ack=%0b", w ? "WR" : "RD", a, d, rd, o_wb_ack);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) @(negedge i_clk);
  endtask

  typedef struct {
    bit          we;
    int          addr;
    logic [31:0] data;
    logic [31:0] exp;
  } vec_t;

  vec_t vt[$];

  initial begin
    #500000;
    n_fail++;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rd, r1, r2;
    int p0, cyc_cnt, hi_r, hi_g, hi_b, hi_other, v, prev, bad_steps, tries;
    bit found;

    // Register table: reset values, read-back, ignored writes and unmapped addresses
    vt.push_back('{1'b0, 0,  32'h0, 32'h0000_0500});
    vt.push_back('{1'b0, 1,  32'h0, 32'h0});
    vt.push_back('{1'b0, 2,  32'h0, 32'h0});
    vt.push_back('{1'b0, 3,  32'h0, 32'h0});
    vt.push_back('{1'b0, 4,  32'h0, 32'h0});
    vt.push_back('{1'b0, 5,  32'h0, 32'h0});
    vt.push_back('{1'b0, 6,  32'h0, 32'h0});
    vt.push_back('{1'b0, 31, 32'h0, 32'h0});
    vt.push_back('{1'b1, 0,  32'h0000_2A01, 32'h0});
    vt.push_back('{1'b0, 0,  32'h0, 32'h0000_2A01});
    vt.push_back('{1'b1, 0,  32'h0000_0001, 32'h0});
    vt.push_back('{1'b0, 0,  32'h0, 32'h0000_0001});
    vt.push_back('{1'b1, 1,  32'hFFFF_FFFF, 32'h0});
    vt.push_back('{1'b0, 1,  32'h0, 32'h0});
    vt.push_back('{1'b1, 2,  32'h8000_0000 | (32'd128 << 20), 32'h0});
    vt.push_back('{1'b0, 2,  32'h0, 32'd128 << 20});
    vt.push_back('{1'b1, 7,  32'hDEAD_BEEF, 32'h0});
    vt.push_back('{1'b0, 7,  32'h0, 32'h0});

    idle(3);
    i_reset_n = 1'b1;
    idle(2);
    check("reset_led", 64'(o_led), 64'd0);

    foreach (vt[i]) begin
      xact(vt[i].we, vt[i].addr, vt[i].data, rd);
      if (!vt[i].we) check($sformatf("vec%0d_addr%0d", i, vt[i].addr), 64'(rd), 64'(vt[i].exp));
    end
    check("no_int_after_reset", 64'(int_pulses), 64'd0);

    // Duty of LED0 R at level 128 over one full PWM period
    hi_r = 0; hi_g = 0; hi_b = 0; hi_other = 0;
    for (int i = 0; i < 512; i++) begin
      @(negedge i_clk);
      hi_r += int'(o_led[2]);
      hi_g += int'(o_led[1]);
      hi_b += int'(o_led[0]);
      hi_other += int'(|o_led[NCH-1:3]);
    end
    check("duty_r", 64'(hi_r), 64'd128);
    check("duty_g", 64'(hi_g), 64'd0);
    check("duty_b", 64'(hi_b), 64'd0);
    check("duty_other_leds", 64'(hi_other), 64'd0);

    // Ramp LED1 G 0 -> 10 at RAMPDIV=3
    xact(1'b1, 0, 32'h0000_0301, rd);
    p0 = int_pulses;
    xact(1'b1, 3, 32'd10 << 10, rd);
    xact(1'b0, 1, 32'h0, rd);
    check("status_ramping", 64'(rd), 64'h2);
    cyc_cnt = 1;
    while (int_pulses == p0 && cyc_cnt < 100) begin
      @(negedge i_clk);
      cyc_cnt++;
    end
    check("ramp_time_in_window", 64'((cyc_cnt >= 34) && (cyc_cnt <= 46)), 64'd1);
    idle(10);
    check("ramp_int_once", 64'(int_pulses - p0), 64'd1);
    xact(1'b0, 3, 32'h0, rd);
    check("ramp_final_level", 64'(rd), 64'(32'd10 << 10));
    xact(1'b0, 1, 32'h0, rd);
    check("status_done", 64'(rd), 64'h0);

    // Reverse mid-ramp: G heading to 10, retarget to 2 when at 5
    xact(1'b1, 3, 32'h8000_0000, rd);
    xact(1'b1, 3, 32'd10 << 10, rd);
    found = 1'b0; tries = 0;
    while (!found && tries < 100) begin
      xact(1'b0, 3, 32'h0, rd);
      if (((rd >> 10) & 32'h3FF) == 32'd5) found = 1'b1;
      tries++;
    end
    check("reached_5", 64'(found), 64'd1);
    p0 = int_pulses;
    xact(1'b1, 3, 32'd2 << 10, rd);
    prev = 5; bad_steps = 0; found = 1'b0; tries = 0;
    while (!found && tries < 60) begin
      xact(1'b0, 3, 32'h0, rd);
      v = int'((rd >> 10) & 32'h3FF);
      if (v - prev > 1 || prev - v > 1) bad_steps++;
      prev = v;
      if (v == 2 && !rd[31]) found = 1'b1;
      tries++;
    end
    check("reverse_no_jump", 64'(bad_steps), 64'd0);
    check("reverse_reached_2", 64'(found), 64'd1);
    idle(3);
    check("reverse_int_once", 64'(int_pulses - p0), 64'd1);

    // Immediate write while ticking every clock: write wins
    xact(1'b1, 0, 32'h0000_0001, rd);
    xact(1'b1, 4, 32'd300, rd);
    p0 = int_pulses;
    xact(1'b1, 4, 32'h8000_0000 | 32'd77, rd);
    xact(1'b0, 4, 32'h0, rd);
    check("imm_vs_tick_level", 64'(rd), 64'd77);
    idle(3);
    check("imm_clear_int", 64'(int_pulses - p0), 64'd1);

    // Disable with LEDs lit: outputs drop, ramps keep going
    xact(1'b1, 5, 32'd200 << 20, rd);
    xact(1'b1, 0, 32'h0000_0000, rd);
    @(negedge i_clk);
    hi_other = 0;
    for (int i = 0; i < 20; i++) begin
      hi_other += int'(|o_led);
      @(negedge i_clk);
    end
    check("disabled_led_low", 64'(hi_other), 64'd0);
    xact(1'b0, 1, 32'h0, rd);
    check("disabled_status_bit3", 64'(rd & 32'h8), 64'h8);
    xact(1'b0, 5, 32'h0, r1);
    idle(3);
    xact(1'b0, 5, 32'h0, r2);
    check("disabled_ramp_moves", 64'(r2[29:20] > r1[29:20]), 64'd1);

    // Reset mid-ramp: outputs clear at once, registers back to reset values
    xact(1'b1, 0, 32'h0000_0301, rd);
    xact(1'b1, 2, 32'h8000_0000 | (32'd400 << 20) | (32'd300 << 10), rd);
    xact(1'b1, 5, 32'd5 << 20, rd);
    idle(2);
    #2;
    i_reset_n = 1'b0;
    #1;
    check("async_reset_outputs", 64'({o_wb_ack, o_int, o_led}), 64'd0);
    check("async_reset_rdata", 64'(o_wb_data), 64'd0);
    idle(2);
    i_reset_n = 1'b1;
    xact(1'b0, 0, 32'h0, rd);
    check("post_reset_ctrl", 64'(rd), 64'h500);
    for (int k = 0; k < NLEDS + 1; k++) begin
      xact(1'b0, 1 + k, 32'h0, rd);
      check($sformatf("post_reset_reg%0d", 1 + k), 64'(rd), 64'd0);
    end

    // Random traffic checked cycle by cycle against the model
    for (int i = 0; i < 1500; i++) begin
      int a;
      logic [31:0] d;
      logic [7:0] dv;
      if ($urandom_range(0, 9) < 3) begin
        idle(1);
      end else begin
        a = int'($urandom_range(0, 7));
        if (a == 0) begin
          dv = 8'($urandom_range(0, 3));
          d = {16'h0, dv, 7'h0, 1'($urandom_range(0, 3) != 0)};
        end else begin
          d = $urandom;
        end
        xact(1'($urandom_range(0, 1)), a, d, rd);
      end
    end
    idle(4);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
